// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (word 0 = ID, word 1 = build
// timestamp), compares both against build-time constants and reports the result.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd7,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1385929362,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        timestamp_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic [7:0]  error_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_ID  = 3'd1;
  localparam logic [2:0] S_LAT_ID = 3'd2;
  localparam logic [2:0] S_RD_TS  = 3'd3;
  localparam logic [2:0] S_LAT_TS = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;

  localparam logic [1:0] LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0] state;
  logic [1:0] lat_cnt;
  logic [7:0] to_cnt;
  logic       id_match, ts_match, lat_done, to_hit, failed;

  assign busy        = (state != S_IDLE);
  assign avm_read    = (state == S_RD_ID) || (state == S_RD_TS);
  assign avm_address = (state == S_RD_TS);

  assign id_match = (avm_readdata == EXPECTED_ID);
  assign ts_match = (avm_readdata == EXPECTED_TIMESTAMP);
  assign lat_done = (lat_cnt == LAT_LAST);
  // this stall cycle would be the TIMEOUT_CYCLES-th in a row
  assign to_hit   = (to_cnt == TO_LAST);
  assign failed   = timeout || !id_ok || !timestamp_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      lat_cnt         <= '0;
      to_cnt          <= '0;
      done            <= 1'b0;
      id_ok           <= 1'b0;
      timestamp_ok    <= 1'b0;
      timeout         <= 1'b0;
      id_value        <= '0;
      timestamp_value <= '0;
      error_count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state           <= S_RD_ID;
          id_ok           <= 1'b0;
          timestamp_ok    <= 1'b0;
          timeout         <= 1'b0;
          id_value        <= '0;
          timestamp_value <= '0;
          lat_cnt         <= '0;
          to_cnt          <= '0;
        end
        S_RD_ID: begin
          if (!avm_waitrequest) begin
            to_cnt <= '0;
            if (READ_LATENCY == 0) begin
              id_value <= avm_readdata;
              id_ok    <= id_match;
              state    <= S_RD_TS;
            end else begin
              lat_cnt <= '0;
              state   <= S_LAT_ID;
            end
          end else if (to_hit) begin
            timeout <= 1'b1;
            to_cnt  <= '0;
            state   <= S_REPORT;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        S_LAT_ID: begin
          if (lat_done) begin
            id_value <= avm_readdata;
            id_ok    <= id_match;
            lat_cnt  <= '0;
            state    <= S_RD_TS;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_RD_TS: begin
          if (!avm_waitrequest) begin
            to_cnt <= '0;
            if (READ_LATENCY == 0) begin
              timestamp_value <= avm_readdata;
              timestamp_ok    <= ts_match;
              state           <= S_REPORT;
            end else begin
              lat_cnt <= '0;
              state   <= S_LAT_TS;
            end
          end else if (to_hit) begin
            timeout <= 1'b1;
            to_cnt  <= '0;
            state   <= S_REPORT;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        S_LAT_TS: begin
          if (lat_done) begin
            timestamp_value <= avm_readdata;
            timestamp_ok    <= ts_match;
            lat_cnt         <= '0;
            state           <= S_REPORT;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_REPORT: begin
          // done is registered so flags and error_count are presented together
          done  <= 1'b1;
          state <= S_IDLE;
          if (failed && error_count != 8'hFF) error_count <= error_count + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboarded bench: u0 uses default parameters, u1 uses READ_LATENCY=2 and
// TIMEOUT_CYCLES=10; slave models return data at the configured latency only.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd7;
  localparam logic [31:0] EXP_TS = 32'd1385929362;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  logic reset;
  logic [1:0] start, wr, addr, rd, busy, done, id_ok, ts_ok, tmo;
  logic [1:0][31:0] rdata, idv, tsv, mem_id, mem_ts;
  logic [1:0][7:0] errc;

  always #5 clock = ~clock;

  sysid_checker u0 (
    .clock(clock), .reset(reset), .start(start[0]),
    .avm_address(addr[0]), .avm_read(rd[0]), .avm_readdata(rdata[0]),
    .avm_waitrequest(wr[0]), .busy(busy[0]), .done(done[0]),
    .id_ok(id_ok[0]), .timestamp_ok(ts_ok[0]), .timeout(tmo[0]),
    .id_value(idv[0]), .timestamp_value(tsv[0]), .error_count(errc[0]));

  sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(10)) u1 (
    .clock(clock), .reset(reset), .start(start[1]),
    .avm_address(addr[1]), .avm_read(rd[1]), .avm_readdata(rdata[1]),
    .avm_waitrequest(wr[1]), .busy(busy[1]), .done(done[1]),
    .id_ok(id_ok[1]), .timestamp_ok(ts_ok[1]), .timeout(tmo[1]),
    .id_value(idv[1]), .timestamp_value(tsv[1]), .error_count(errc[1]));

  // slave models: data valid only in the cycle the master should capture it
  logic p1v = 1'b0, p2v = 1'b0, p1a = 1'b0, p2a = 1'b0;
  always @(posedge clock) begin
    p1v <= rd[1] && !wr[1];
    p1a <= addr[1];
    p2v <= p1v;
    p2a <= p1a;
  end
  assign rdata[0] = (rd[0] && !wr[0]) ? (addr[0] ? mem_ts[0] : mem_id[0]) : JUNK;
  assign rdata[1] = p2v ? (p2a ? mem_ts[1] : mem_id[1]) : JUNK;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int rd_n = 0;
  logic [3:0] rd_addrs = '0;
  always @(negedge clock) if (rd[0]) begin
    rd_n     <= rd_n + 1;
    rd_addrs <= {rd_addrs[2:0], addr[0]};
  end

  typedef struct {
    int          k;
    logic        idk, tsk, to;
    logic [31:0] idv, tsv;
    logic [7:0]  err;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;
  int exp_err[2] = '{0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string p, input int k);
    chk({p, "_ctrl"}, {busy[k], done[k], rd[k], addr[k], id_ok[k], ts_ok[k], tmo[k]}, 0);
    chk({p, "_idv"}, idv[k], 0);
    chk({p, "_tsv"}, tsv[k], 0);
    chk({p, "_err"}, errc[k], 0);
  endtask

  // pulse start on instance k; returns at the negedge after the sampling edge
  task automatic launch(input int k, input int lat, input logic to);
    exp_t x;
    x.k   = k;
    x.to  = to;
    x.idk = to ? 1'b0 : (mem_id[k] == EXP_ID);
    x.tsk = to ? 1'b0 : (mem_ts[k] == EXP_TS);
    x.idv = to ? 32'd0 : mem_id[k];
    x.tsv = to ? 32'd0 : mem_ts[k];
    if ((to || !x.idk || !x.tsk) && exp_err[k] < 255) exp_err[k]++;
    x.err = 8'(exp_err[k]);
    @(negedge clock) start[k] = 1'b1;
    @(posedge clock);
    #1 x.at = cyc + lat;
    sb.push_back(x);
    @(negedge clock) start[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while ((sb.size() != 0 || busy[k]) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("wait_bound", n < 100, 1);
  endtask

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (done[k]) begin
        if (sb.size() == 0 || sb[0].k != k) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.at);
          chk("id_ok", id_ok[k], e.idk);
          chk("ts_ok", ts_ok[k], e.tsk);
          chk("timeout", tmo[k], e.to);
          chk("id_value", idv[k], e.idv);
          chk("ts_value", tsv[k], e.tsv);
          chk("err_count", errc[k], e.err);
          chk("read_at_done", rd[k], 0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset = 1'b1;
    start = '0;
    wr    = '0;
    mem_id = {EXP_ID, EXP_ID};
    mem_ts = {EXP_TS, EXP_TS};
    repeat (3) @(negedge clock);
    chk_zero("rst_u0", 0);
    chk_zero("rst_u1", 1);
    reset = 1'b0;
    @(negedge clock);

    // nominal read, two read cycles: address 0 then 1
    n0 = rd_n;
    launch(0, 3, 1'b0);
    wait_idle(0);
    chk("rd_cycles", rd_n - n0, 2);
    chk("rd_addr_seq", rd_addrs[1:0], 2'b01);

    // wrong ID repeatedly: error_count saturates
    mem_id[0] = 32'd8;
    repeat (300) begin
      launch(0, 3, 1'b0);
      wait_idle(0);
    end
    chk("err_saturated", errc[0], 8'd255);
    mem_id[0] = EXP_ID;

    // latency 2, no stall
    launch(1, 7, 1'b0);
    wait_idle(1);

    // latency 2 with 4 stall cycles on the ID read
    wr[1] = 1'b1;
    launch(1, 11, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      chk("stall_read", rd[1], 1);
      chk("stall_addr", addr[1], 0);
    end
    @(negedge clock) wr[1] = 1'b0;
    wait_idle(1);

    // waitrequest stuck: abort after 10 stall cycles
    wr[1] = 1'b1;
    launch(1, 11, 1'b1);
    repeat (9) @(negedge clock);
    chk("to_read_before", rd[1], 1);
    @(negedge clock);
    chk("to_read_after", rd[1], 0);
    chk("to_busy_report", busy[1], 1);
    wait_idle(1);
    wr[1] = 1'b0;

    // start re-pulsed in RD_TS and REPORT: exactly one done
    launch(0, 3, 1'b0);
    @(negedge clock) start[0] = 1'b1;
    @(negedge clock);
    @(negedge clock) start[0] = 1'b0;
    repeat (5) @(negedge clock);
    chk("repulse_idle", busy[0], 0);
    wait_idle(0);

    // reset during LAT_ID abandons the check
    @(negedge clock) start[1] = 1'b1;
    @(negedge clock) start[1] = 1'b0;
    @(negedge clock);
    chk("lat_id_busy", {busy[1], rd[1]}, 2'b10);
    reset = 1'b1;
    exp_err = '{0, 0};
    @(negedge clock);
    chk_zero("midrst_u1", 1);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("midrst_idle", busy[1], 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
